gray_updown_counter: RTL and testbench

Parametrised up/down Gray-code counter with enable, parallel load, and wrap or saturate mode. Both Gray and binary outputs are registered, and a one-cycle wrap/limit event pulse is provided. It is the general-purpose successor to the fixed-width Gray counters. It is intended for FIFO pointers, async-crossing counters and position trackers, where exactly one output bit may change per step.

---
 rtl/gray_updown_counter.sv | 79 +++++++
 tb/tb_gray_updown_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/gray_updown_counter.sv
// rtl/gray_updown_counter.sv - parametrised up/down Gray counter with load and wrap/saturate modes
module gray_updown_counter #(
    parameter int unsigned WIDTH    = 5,
    parameter bit          SATURATE = 1'b0,
    parameter int unsigned RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             evt,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] RST_BIN  = RST_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             evt_q;
    logic [WIDTH-1:0] bin_d;
    logic             evt_d;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    always_comb begin
        bin_d = bin_q;
        evt_d = 1'b0;
        if (load) begin
            bin_d = load_val;
        end else if (en) begin
            if (up) begin
                if (bin_q == MAX_VAL) begin
                    bin_d = SATURATE ? bin_q : ZERO;
                    evt_d = 1'b1;
                end else begin
                    bin_d = bin_q + ONE;
                end
            end else begin
                if (bin_q == ZERO) begin
                    bin_d = SATURATE ? bin_q : MAX_VAL;
                    evt_d = 1'b1;
                end else begin
                    bin_d = bin_q - ONE;
                end
            end
        end
    end

    // Gray register is fed from the next binary value so both outputs stay glitch-free registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            evt_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= to_gray(bin_d);
            evt_q  <= evt_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign evt      = evt_q;
    assign at_max   = (bin_q == MAX_VAL);
    assign at_min   = (bin_q == ZERO);

endmodule

// File: tb/tb_gray_updown_counter.sv
// tb/tb_gray_updown_counter.sv - directed bench for wrap and saturate instances of gray_updown_counter
module tb_gray_updown_counter;

    logic       clk = 1'b0;
    logic       a_srst, a_en, a_up, a_load;
    logic [4:0] a_load_val, a_bin, a_gray;
    logic       a_evt, a_max, a_min;
    logic       b_srst, b_en, b_up, b_load;
    logic [4:0] b_load_val, b_bin, b_gray;
    logic       b_evt, b_max, b_min;
    int         total = 0;
    int         bad   = 0;
    logic [4:0] prev_gray;

    always #5 clk = ~clk;

    gray_updown_counter #(.WIDTH(5), .SATURATE(1'b0), .RST_VAL(0)) u_wrap (
        .clk(clk), .srst(a_srst), .en(a_en), .up(a_up), .load(a_load), .load_val(a_load_val),
        .bin_out(a_bin), .gray_out(a_gray), .evt(a_evt), .at_max(a_max), .at_min(a_min)
    );

    gray_updown_counter #(.WIDTH(5), .SATURATE(1'b1), .RST_VAL(5)) u_sat (
        .clk(clk), .srst(b_srst), .en(b_en), .up(b_up), .load(b_load), .load_val(b_load_val),
        .bin_out(b_bin), .gray_out(b_gray), .evt(b_evt), .at_max(b_max), .at_min(b_min)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_srst = 1'b1; a_en = 1'b1; a_up = 1'b1; a_load = 1'b0; a_load_val = '0;
        b_srst = 1'b1; b_en = 1'b0; b_up = 1'b1; b_load = 1'b0; b_load_val = '0;

        // Wrap instance: reset held with en high
        repeat (3) tick();
        check("rst_bin", a_bin, 0);
        check("rst_gray", a_gray, 5'b00000);
        check("rst_evt", a_evt, 0);
        check("rst_min", a_min, 1);
        check("rst_max", a_max, 0);

        a_srst = 1'b0;
        tick();
        check("rel_bin", a_bin, 1);
        check("rel_gray", a_gray, 5'b00001);
        prev_gray = a_gray;

        for (int i = 2; i <= 31; i++) begin
            tick();
            check("up_bin", a_bin, i);
            check("up_gray", a_gray, i ^ (i >> 1));
            check("up_step1", $countones(a_gray ^ prev_gray), 1);
            check("up_evt", a_evt, 0);
            prev_gray = a_gray;
        end
        check("top_gray", a_gray, 5'b10000);
        check("top_max", a_max, 1);

        tick();
        check("wrap_bin", a_bin, 0);
        check("wrap_gray", a_gray, 5'b00000);
        check("wrap_step1", $countones(a_gray ^ prev_gray), 1);
        check("wrap_evt", a_evt, 1);

        a_en = 1'b0;
        tick();
        check("idle_bin", a_bin, 0);
        check("idle_evt", a_evt, 0);

        a_en = 1'b1; a_up = 1'b0;
        tick();
        check("dwrap_bin", a_bin, 31);
        check("dwrap_gray", a_gray, 5'b10000);
        check("dwrap_evt", a_evt, 1);
        tick();
        check("down_bin", a_bin, 30);
        check("down_gray", a_gray, 5'b10001);
        check("down_evt", a_evt, 0);

        a_up = 1'b1; a_load = 1'b1; a_load_val = 5'd13;
        tick();
        check("load_bin", a_bin, 13);
        check("load_gray", a_gray, 5'b01011);
        check("load_evt", a_evt, 0);

        a_srst = 1'b1;
        tick();
        check("rstload_bin", a_bin, 0);
        check("rstload_gray", a_gray, 0);

        // Load overriding a wrapping step must not raise evt
        a_srst = 1'b0; a_load_val = 5'd31;
        tick();
        a_load_val = 5'd4;
        tick();
        check("loadwrap_bin", a_bin, 4);
        check("loadwrap_evt", a_evt, 0);

        a_load_val = 5'd16;
        tick();
        a_load = 1'b0;
        tick();
        check("mid_bin", a_bin, 17);
        a_srst = 1'b1;
        tick();
        check("mid_rst_bin", a_bin, 0);
        check("mid_rst_evt", a_evt, 0);
        a_srst = 1'b0;
        tick();
        check("resume_bin", a_bin, 1);
        a_en = 1'b0;

        // Saturate instance with RST_VAL=5
        tick();
        check("s_rst_bin", b_bin, 5);
        check("s_rst_gray", b_gray, 5'b00111);
        check("s_rst_min", b_min, 0);
        check("s_rst_max", b_max, 0);

        b_srst = 1'b0; b_load = 1'b1; b_load_val = 5'd30;
        tick();
        check("s_load_bin", b_bin, 30);
        b_load = 1'b0; b_en = 1'b1; b_up = 1'b1;
        tick();
        check("s_up1_bin", b_bin, 31);
        check("s_up1_evt", b_evt, 0);
        tick();
        check("s_up2_bin", b_bin, 31);
        check("s_up2_evt", b_evt, 1);
        tick();
        check("s_up3_bin", b_bin, 31);
        check("s_up3_evt", b_evt, 1);
        check("s_up3_gray", b_gray, 5'b10000);
        check("s_max", b_max, 1);

        b_up = 1'b0;
        tick();
        check("s_dn_bin", b_bin, 30);
        check("s_dn_evt", b_evt, 0);

        b_load = 1'b1; b_load_val = 5'd1;
        tick();
        b_load = 1'b0;
        tick();
        check("s_lo1_bin", b_bin, 0);
        check("s_lo1_evt", b_evt, 0);
        tick();
        check("s_lo2_bin", b_bin, 0);
        check("s_lo2_evt", b_evt, 1);
        check("s_min", b_min, 1);

        b_up = 1'b1; b_srst = 1'b1;
        tick();
        check("s_mid_rst_bin", b_bin, 5);
        check("s_mid_rst_evt", b_evt, 0);
        b_srst = 1'b0;
        tick();
        check("s_resume_bin", b_bin, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
